// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (instruction fetch / data load-store) arbiter for a
//               single 64-bit-word memory with fixed read latency MEM_LAT.
//               Serves one access at a time:
//                 IDLE  -> ISSUE : mem_en pulse for one cycle
//                 ISSUE -> WAIT  : MEM_LAT cycles
//                 WAIT  -> RESP  : one-cycle ack
//                 RESP  -> IDLE
//               Optional macro MEM_ARBITER_RR_EN: round-robin on conflict.
//               When it is undefined, data always wins a conflict.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_BITS = 6,
  parameter int MEM_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req,
  input  logic [ADDR_BITS:0]   i_addr,
  output logic                 i_ack,
  output logic [31:0]          i_rdata,
  input  logic                 d_re,
  input  logic                 d_we,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [63:0]          d_wdata,
  output logic                 d_ack,
  output logic [63:0]          d_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [63:0]          mem_wdata,
  input  logic [63:0]          mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Counter value on the cycle in which mem_rdata is valid
  localparam logic [3:0] C_LAST_CNT = 4'(MEM_LAT - 1);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   grant_data_q, grant_data_d;
  logic                   write_q, write_d;
  logic                   half_q, half_d;
  logic                   mem_en_q, mem_en_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [63:0]            mem_wdata_q, mem_wdata_d;
  logic                   i_ack_q, i_ack_d;
  logic                   d_ack_q, d_ack_d;
  logic [31:0]            i_rdata_q, i_rdata_d;
  logic [63:0]            d_rdata_q, d_rdata_d;
`ifdef MEM_ARBITER_RR_EN
  logic                   last_data_q, last_data_d;
`endif

  logic w_d_req;
  logic w_pick_data;

  // Grant selection; a simultaneous read+write counts as a data request
  always_comb begin
    w_d_req = d_re | d_we;
`ifdef MEM_ARBITER_RR_EN
    // On conflict, go to whichever side was not granted last
    w_pick_data = w_d_req & (~i_req | ~last_data_q);
`else
    w_pick_data = w_d_req;
`endif
  end

  // Next-state and next-output computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_data_d = grant_data_q;
    write_d      = write_q;
    half_d       = half_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
`ifdef MEM_ARBITER_RR_EN
    last_data_d  = last_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req || w_d_req) begin
          state_d      = ISSUE;
          grant_data_d = w_pick_data;
          write_d      = w_pick_data & d_we;
          half_d       = i_addr[0];
          mem_en_d     = 1'b1;
          mem_we_d     = w_pick_data & d_we;
          mem_addr_d   = w_pick_data ? d_addr : i_addr[ADDR_BITS:1];
          if (w_pick_data) begin
            mem_wdata_d = d_wdata;
          end
`ifdef MEM_ARBITER_RR_EN
          last_data_d  = w_pick_data;
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 4'd0;
      end
      WAIT: begin
        if (cnt_q == C_LAST_CNT) begin
          state_d = RESP;
          if (grant_data_q) begin
            d_ack_d = 1'b1;
            if (!write_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = half_q ? mem_rdata[63:32] : mem_rdata[31:0];
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        // Requests are not looked at here; the ack pulse ends this cycle
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      grant_data_q <= 1'b0;
      write_q      <= 1'b0;
      half_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_data_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_data_q <= grant_data_d;
      write_q      <= write_d;
      half_q       <= half_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
`ifdef MEM_ARBITER_RR_EN
      last_data_q  <= last_data_d;
`endif
    end
  end

  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a
//               behavioural fixed-latency memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int AB  = 6;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AB:0]   i_addr = '0;
  logic          i_ack;
  logic [31:0]   i_rdata;
  logic          d_re = 1'b0;
  logic          d_we = 1'b0;
  logic [AB-1:0] d_addr = '0;
  logic [63:0]   d_wdata = '0;
  logic          d_ack;
  logic [63:0]   d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AB-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_BITS(AB), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: read data appears LAT cycles after the mem_en cycle and
  // holds a garbage pattern on every other cycle.
  logic          pl_en = 1'b0;
  logic [AB-1:0] pl_addr = '0;
  logic [63:0]   pl_data = '0;
  logic [63:0]   mem  [0:(1<<AB)-1];
  logic [63:0]   pipe [0:LAT-1];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rdata = pipe[LAT-1];

  // Event monitor sampled 1 time unit after each rising edge
  int            cyc = 0;
  int            en_cnt = 0;
  int            en_cyc = 0;
  int            iack_cnt = 0;
  int            dack_cnt = 0;
  int            ack_cyc = 0;
  logic [AB-1:0] en_addr = '0;
  logic          en_we = 1'b0;
  logic [63:0]   en_wdata = '0;
  bit            gl[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (mem_en) begin
      en_cnt++; en_cyc = cyc; en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata;
    end
    if (i_ack) begin iack_cnt++; ack_cyc = cyc; gl.push_back(1'b0); end
    if (d_ack) begin dack_cnt++; ack_cyc = cyc; gl.push_back(1'b1); end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access: raise request at a falling edge, drop it once mem_en is
  // seen, wait (bounded) for the ack, then let the arbiter settle.
  task automatic access(input bit ir, input bit dr, input bit dw,
                        input logic [AB:0] ia, input logic [AB-1:0] da,
                        input logic [63:0] wd,
                        output int start, output int e0, output int i0, output int d0);
    @(negedge clk);
    i_req = ir; d_re = dr; d_we = dw; i_addr = ia; d_addr = da; d_wdata = wd;
    start = cyc; e0 = en_cnt; i0 = iack_cnt; d0 = dack_cnt;
    for (int n = 0; n < 30 && (iack_cnt + dack_cnt) == (i0 + d0); n++) begin
      @(negedge clk);
      if (en_cnt != e0) begin i_req = 1'b0; d_re = 1'b0; d_we = 1'b0; end
    end
    i_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic verify(input string tag, input int start, input int e0, input int i0,
                        input int d0, input bit exp_d, input logic [AB-1:0] ea, input bit ewe);
    check({tag, "_issue_cyc"}, 64'(en_cyc - start), 64'(1));
    check({tag, "_ack_lat"},   64'(ack_cyc - en_cyc), 64'(LAT + 1));
    check({tag, "_en_pulses"}, 64'(en_cnt - e0), 64'(1));
    check({tag, "_iack"},      64'(iack_cnt - i0), exp_d ? 64'(0) : 64'(1));
    check({tag, "_dack"},      64'(dack_cnt - d0), exp_d ? 64'(1) : 64'(0));
    check({tag, "_addr"},      64'(en_addr), 64'(ea));
    check({tag, "_we"},        64'(en_we), 64'(ewe));
  endtask

  initial begin
    int st, e0, i0, d0, idx;
    bit exp_order [0:3];
    logic [63:0] got;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_en", 64'(mem_en), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_i_ack", 64'(i_ack), 64'(0));
    check("rst_d_ack", 64'(d_ack), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", mem_wdata, 64'(0));
    check("rst_i_rdata", 64'(i_rdata), 64'(0));
    check("rst_d_rdata", d_rdata, 64'(0));

    // Preload word 2 through the model's back door
    pl_en = 1'b1; pl_addr = 6'd2; pl_data = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    pl_en = 1'b0;
    rst_n = 1'b1;

    // Fetch of upper half (i_addr=5 -> word 2, bits 63:32)
    access(1'b1, 1'b0, 1'b0, 7'd5, 6'd0, 64'd0, st, e0, i0, d0);
    verify("fetch5", st, e0, i0, d0, 1'b0, 6'd2, 1'b0);
    check("fetch5_rdata", 64'(i_rdata), 64'hAAAA_BBBB);

    // Fetch of lower half (i_addr=4 -> word 2, bits 31:0)
    access(1'b1, 1'b0, 1'b0, 7'd4, 6'd0, 64'd0, st, e0, i0, d0);
    verify("fetch4", st, e0, i0, d0, 1'b0, 6'd2, 1'b0);
    check("fetch4_rdata", 64'(i_rdata), 64'hCCCC_DDDD);

    // Store then load back
    access(1'b0, 1'b0, 1'b1, 7'd0, 6'd7, 64'h1234, st, e0, i0, d0);
    verify("store7", st, e0, i0, d0, 1'b1, 6'd7, 1'b1);
    check("store7_wdata", en_wdata, 64'h1234);
    access(1'b0, 1'b1, 1'b0, 7'd0, 6'd7, 64'd0, st, e0, i0, d0);
    verify("load7", st, e0, i0, d0, 1'b1, 6'd7, 1'b0);
    check("load7_rdata", d_rdata, 64'h1234);
    check("i_rdata_hold", 64'(i_rdata), 64'hCCCC_DDDD);

    // Read and write together act as a write
    access(1'b0, 1'b1, 1'b1, 7'd0, 6'd9, 64'h55, st, e0, i0, d0);
    verify("rw9", st, e0, i0, d0, 1'b1, 6'd9, 1'b1);
    check("rw9_mem", mem[9], 64'h55);
    check("d_rdata_hold", d_rdata, 64'h1234);

    // Reset in the middle of WAIT
    @(negedge clk);
    i_req = 1'b1; i_addr = 7'd5;
    e0 = en_cnt; i0 = iack_cnt; d0 = dack_cnt;
    @(negedge clk);                 // ISSUE
    i_req = 1'b0;
    @(negedge clk);                 // WAIT
    rst_n = 1'b0;
    #1;
    check("midrst_mem_en", 64'(mem_en), 64'(0));
    check("midrst_i_rdata", 64'(i_rdata), 64'(0));
    repeat (5) @(negedge clk);
    check("midrst_iack", 64'(iack_cnt - i0), 64'(0));
    check("midrst_dack", 64'(dack_cnt - d0), 64'(0));
    check("midrst_en_pulses", 64'(en_cnt - e0), 64'(1));

    // Conflict: both sides request continuously from the first cycle after reset
    rst_n = 1'b1;
    i_req = 1'b1; i_addr = 7'd4; d_re = 1'b1; d_addr = 6'd7;
    st = cyc; e0 = en_cnt; i0 = iack_cnt; d0 = dack_cnt; idx = gl.size();
    for (int n = 0; n < 80 && (iack_cnt + dack_cnt - i0 - d0) < 4; n++) @(negedge clk);
    i_req = 1'b0; d_re = 1'b0;
    repeat (3) @(negedge clk);
    check("conf_acks", 64'(iack_cnt + dack_cnt - i0 - d0), 64'(4));
    check("conf_en_pulses", 64'(en_cnt - e0), 64'(4));
    check("conf_last_ack_cyc", 64'(ack_cyc - st), 64'(4 * (LAT + 3) - 1));
`ifdef MEM_ARBITER_RR_EN
    exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1; exp_order[3] = 1'b0;
`else
    exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1; exp_order[3] = 1'b1;
`endif
    for (int k = 0; k < 4; k++) begin
      got = (idx + k < gl.size()) ? 64'(gl[idx + k]) : 64'd2;
      check($sformatf("conf_order%0d", k), got, 64'(exp_order[k]));
    end
    check("conf_d_rdata", d_rdata, 64'h1234);
`ifdef MEM_ARBITER_RR_EN
    check("conf_i_rdata", 64'(i_rdata), 64'hCCCC_DDDD);
`else
    check("conf_i_rdata", 64'(i_rdata), 64'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 6, the 64-bit-word address width of the shared memory.
REQ-002 SHALL have parameter MEM_LAT, default 2, the memory read latency in cycles; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_req  input  1  instruction-fetch request.
REQ-006 SHALL have port i_addr  input  ADDR_BITS+1  32-bit-word fetch address.
REQ-007 SHALL have port i_ack  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port i_rdata  output  32  fetched instruction, valid while i_ack=1.
REQ-009 SHALL have port d_re  input  1  data read request.
REQ-010 SHALL have port d_we  input  1  data write request.
REQ-011 SHALL have port d_addr  input  ADDR_BITS  64-bit-word data address.
REQ-012 SHALL have port d_wdata  input  64  store data.
REQ-013 SHALL have port d_ack  output  1  one-cycle data completion pulse.
REQ-014 SHALL have port d_rdata  output  64  load data, valid while d_ack=1.
REQ-015 SHALL have port mem_en  output  1  memory access strobe.
REQ-016 SHALL have port mem_we  output  1  memory write enable, qualified by mem_en.
REQ-017 SHALL have port mem_addr  output  ADDR_BITS  memory word address.
REQ-018 SHALL have port mem_wdata  output  64  memory write data.
REQ-019 SHALL have port mem_rdata  input  64  memory read data.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-021 SHALL, in IDLE with any request high, latch grant, address, data and direction and move to ISSUE; otherwise stay in IDLE.
REQ-022 SHALL, in ISSUE (cycle T), assert mem_en=1 for exactly one cycle, mem_we=1 only for data writes; ISSUE -> WAIT.
REQ-023 SHALL stay in WAIT until the latency counter, cleared in ISSUE, reaches MEM_LAT-1; mem_rdata is valid in cycle T+MEM_LAT and is captured at its end.
REQ-024 SHALL, in RESP (cycle T+MEM_LAT+1), pulse exactly one of i_ack/d_ack for one cycle, then return to IDLE; requests are ignored in RESP.
REQ-025 SHALL map a fetch to mem_addr=i_addr[ADDR_BITS:1], with i_rdata = mem_rdata[31:0] if i_addr[0]=0, else mem_rdata[63:32].
REQ-026 SHALL complete writes with the same timing as reads; d_rdata is don't-care for writes.
REQ-027 SHALL treat d_re=1 and d_we=1 together as a write.
REQ-028 SHALL, if a requester drops its request after the grant, still complete the access and pulse ack.
REQ-029 SHALL hold i_rdata/d_rdata at their last values outside ack cycles.
REQ-030 SHALL, when both sides request in IDLE, resolve per REQ-034/035.

Reset
REQ-031 SHALL, on rst_n=0 at any time including mid-access, force IDLE, clear the counter, and drive mem_en, mem_we, i_ack and d_ack to 0, mem_addr, mem_wdata, i_rdata and d_rdata to 0, and the last-grant register to instruction.
REQ-032 SHALL discard any in-flight access on reset; no ack is issued for it.
REQ-033 SHALL accept requests in the first cycle after rst_n rises.

Configuration
REQ-034 SHALL, with macro MEM_ARBITER_RR_EN defined, grant on conflict to the side not granted last; the first conflict after reset goes to data.
REQ-035 SHALL, without MEM_ARBITER_RR_EN, always grant data over instruction on conflict.

Verification
REQ-036 Fetch i_addr=5, MEM_LAT=2, mem word 2 = 0xAAAA_BBBB_CCCC_DDDD -> mem_en at T with mem_addr=2, i_ack at T+3, i_rdata=0xAAAABBBB.
REQ-037 Store d_addr=7, d_wdata=0x1234 -> one mem_en/mem_we pulse with mem_addr=7, d_ack at T+3; load of addr 7 returns 0x1234.
REQ-038 i_req and d_re held high together for 4 accesses -> without macro order D,D,D,D; with MEM_ARBITER_RR_EN order D,I,D,I.
REQ-039 rst_n low during WAIT -> i_ack/d_ack never pulse, mem_en=0, next request served with normal latency.
REQ-040 d_re and d_we both high -> mem_we=1; i_req dropped after grant -> i_ack still pulses once.
